// File: rtl/aes_subbytes_serial_umsk.sv
// Iterative unmasked AES SubBytes: NSBOX S-boxes applied per cycle to a rotating 128-bit state.
// Functional reference for the masked round pipeline.

module sbox_bp_umsk (
  input  logic [7:0] i_x,
  output logic [7:0] o_y
);

  localparam logic [7:0] SBOX_LUT [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign o_y = SBOX_LUT[i_x];

endmodule

module aes_subbytes_serial_umsk #(
  parameter int unsigned NSBOX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  localparam int unsigned NCYC = 16 / NSBOX;
  localparam int unsigned CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam int unsigned SW   = 8 * NSBOX;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(NCYC - 1);

  logic [1:0]    r_fsm;
  logic [CW-1:0] r_cnt;
  logic [127:0]  r_state;
  logic [SW-1:0] w_sub;
  logic [127:0]  w_rot;

  generate
    if (NSBOX != 1 && NSBOX != 2 && NSBOX != 4 && NSBOX != 8 && NSBOX != 16) begin : g_bad_nsbox
      $error("aes_subbytes_serial_umsk: NSBOX must be one of 1, 2, 4, 8, 16");
    end

    for (genvar g = 0; g < int'(NSBOX); g++) begin : g_sbox
      sbox_bp_umsk u_sbox (
        .i_x (r_state[8*g +: 8]),
        .o_y (w_sub[8*g +: 8])
      );
    end

    // Substituted low bytes re-enter at the top, so NCYC rotations restore byte order.
    if (NSBOX == 16) begin : g_rot_full
      assign w_rot = w_sub;
    end else begin : g_rot_part
      assign w_rot = {w_sub, r_state[127:SW]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm   <= ST_IDLE;
      r_cnt   <= '0;
      r_state <= '0;
    end else begin
      case (r_fsm)
        ST_IDLE: begin
          if (in_valid) begin
            r_state <= in_state;
            r_cnt   <= '0;
            r_fsm   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_state <= w_rot;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_fsm <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_fsm <= ST_IDLE;
          end
        end
        default: r_fsm <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_fsm == ST_IDLE);
  assign out_valid = (r_fsm == ST_DONE);
  assign out_state = r_state;

endmodule

// File: tb/tb_aes_subbytes_serial_umsk.sv
// Bench for aes_subbytes_serial_umsk: one instance per legal NSBOX, checked against a
// GF(2^8) inverse + affine S-box model.

module tb_aes_subbytes_serial_umsk;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [5];
  logic         in_ready  [5];
  logic [127:0] in_state  [5];
  logic         out_valid [5];
  logic         out_ready [5];
  logic [127:0] out_state [5];

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;

  logic [7:0]   ref_tab [256];
  logic [127:0] exp_mem [5][2048];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance k uses NSBOX = 2**k.
  for (genvar g = 0; g < 5; g++) begin : g_dut
    aes_subbytes_serial_umsk #(.NSBOX(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g])
    );
  end

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in;
    logic [7:0] b = b_in;
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_sub(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = ref_tab[s[8*i +: 8]];
    return r;
  endfunction

  function automatic int ncyc(input int k);
    return 16 >> k;
  endfunction

  task automatic init_model();
    logic [7:0] inv, xb, yb;
    for (int x = 0; x < 256; x++) begin
      xb  = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        yb = 8'(y);
        if (gmul(xb, yb) == 8'h01) inv = yb;
      end
      ref_tab[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic idle_all();
    for (int k = 0; k < 5; k++) begin
      in_valid[k]  = 1'b0;
      in_state[k]  = '0;
      out_ready[k] = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      total++;
      if (in_ready[k] !== 1'b1) begin
        bad++; $display("FAIL reset_in_ready k=%0d got=%b exp=1", k, in_ready[k]);
      end
      total++;
      if (out_valid[k] !== 1'b0) begin
        bad++; $display("FAIL reset_out_valid k=%0d got=%b exp=0", k, out_valid[k]);
      end
      total++;
      if (out_state[k] !== 128'h0) begin
        bad++; $display("FAIL reset_state k=%0d got=%h exp=0", k, out_state[k]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One transfer with out_ready=1; checks latency, result and the single-cycle valid pulse.
  task automatic run_one(input int k, input logic [127:0] st, input logic [127:0] expc,
                         input bit chk_const);
    int lat;
    bit seen;
    @(negedge clk);
    total++;
    if (in_ready[k] !== 1'b1) begin
      bad++; $display("FAIL run_idle_ready k=%0d got=%b exp=1", k, in_ready[k]);
    end
    in_valid[k]  = 1'b1;
    in_state[k]  = st;
    out_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    in_state[k] = ~st;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) begin
        total++;
        if (in_ready[k] !== 1'b0) begin
          bad++; $display("FAIL run_busy_ready k=%0d got=%b exp=0", k, in_ready[k]);
        end
      end
      if (out_valid[k] === 1'b1) seen = 1'b1;
    end
    total++;
    if (lat != ncyc(k) || !seen) begin
      bad++; $display("FAIL run_latency k=%0d got=%0d exp=%0d", k, lat, ncyc(k));
    end
    total++;
    if (out_state[k] !== ref_sub(st)) begin
      bad++; $display("FAIL run_model k=%0d got=%h exp=%h", k, out_state[k], ref_sub(st));
    end
    if (chk_const) begin
      total++;
      if (out_state[k] !== expc) begin
        bad++; $display("FAIL run_vector k=%0d got=%h exp=%h", k, out_state[k], expc);
      end
    end
    @(negedge clk);
    total++;
    if (out_valid[k] !== 1'b0) begin
      bad++; $display("FAIL run_valid_pulse k=%0d got=%b exp=0", k, out_valid[k]);
    end
  endtask

  task automatic test_zero();
    run_one(2, 128'h0, {16{8'h63}}, 1'b1);
  endtask

  task automatic test_vector();
    for (int k = 0; k < 5; k++) begin
      run_one(k, 128'hffeeddccbbaa99887766554433221100,
              128'h1628c14beaaceec4f533fc1bc3938263, 1'b1);
    end
  endtask

  task automatic test_backpressure();
    int k = 2;
    int guard = 0;
    bit late_out = 1'b0;
    logic [127:0] st = {$urandom(), $urandom(), $urandom(), $urandom()};
    @(negedge clk);
    in_valid[k]  = 1'b1;
    in_state[k]  = st;
    out_ready[k] = 1'b0;
    @(posedge clk);
    #1 in_valid[k] = 1'b0;
    @(negedge clk);
    while (out_valid[k] !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 10; i++) begin
      in_valid[k] = 1'b1;
      in_state[k] = ~st;
      total++;
      if (out_valid[k] !== 1'b1) begin
        bad++; $display("FAIL bp_valid k=%0d cyc=%0d got=%b exp=1", k, i, out_valid[k]);
      end
      total++;
      if (out_state[k] !== ref_sub(st)) begin
        bad++; $display("FAIL bp_state cyc=%0d got=%h exp=%h", i, out_state[k], ref_sub(st));
      end
      total++;
      if (in_ready[k] !== 1'b0) begin
        bad++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready[k]);
      end
      @(negedge clk);
    end
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
      bad++; $display("FAIL bp_release got valid=%b ready=%b exp valid=0 ready=1",
                      out_valid[k], in_ready[k]);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid[k] === 1'b1) late_out = 1'b1;
    end
    total++;
    if (late_out) begin
      bad++; $display("FAIL bp_ignored_input got out_valid=1 exp=0");
    end
  endtask

  task automatic test_back_to_back();
    int k = 2;
    int acc_n = 0;
    int hs_n = 0;
    int guard = 0;
    int unsigned acc_cyc [2];
    int unsigned hs_cyc [2];
    logic [127:0] outs [2];
    logic [127:0] a = {$urandom(), $urandom(), $urandom(), $urandom()};
    logic [127:0] b = {$urandom(), $urandom(), $urandom(), $urandom()};
    @(negedge clk);
    in_valid[k]  = 1'b1;
    in_state[k]  = a;
    out_ready[k] = 1'b1;
    while (hs_n < 2 && guard < 60) begin
      if (in_valid[k] && in_ready[k] === 1'b1 && acc_n < 2) begin
        acc_cyc[acc_n] = cyc;
        acc_n++;
      end
      if (out_valid[k] === 1'b1) begin
        hs_cyc[hs_n] = cyc;
        outs[hs_n]   = out_state[k];
        hs_n++;
      end
      @(posedge clk);
      #1;
      if (acc_n == 1) in_state[k] = b;
      if (acc_n == 2) in_valid[k] = 1'b0;
      @(negedge clk);
      guard++;
    end
    in_valid[k] = 1'b0;
    total++;
    if (acc_n != 2 || hs_n != 2) begin
      bad++; $display("FAIL b2b_count got acc=%0d hs=%0d exp=2,2", acc_n, hs_n);
    end else begin
      total++;
      if (acc_cyc[1] - hs_cyc[0] != 1) begin
        bad++; $display("FAIL b2b_gap got=%0d exp=1", acc_cyc[1] - hs_cyc[0]);
      end
      total++;
      if (acc_cyc[1] - acc_cyc[0] != 6) begin
        bad++; $display("FAIL b2b_period got=%0d exp=6", acc_cyc[1] - acc_cyc[0]);
      end
      total++;
      if (outs[0] !== ref_sub(a)) begin
        bad++; $display("FAIL b2b_first got=%h exp=%h", outs[0], ref_sub(a));
      end
      total++;
      if (outs[1] !== ref_sub(b)) begin
        bad++; $display("FAIL b2b_second got=%h exp=%h", outs[1], ref_sub(b));
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    int k = 2;
    bit late_out = 1'b0;
    @(negedge clk);
    in_valid[k] = 1'b1;
    in_state[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
    @(posedge clk);
    #1 in_valid[k] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0) begin
      bad++; $display("FAIL midrst_abort got ready=%b valid=%b exp ready=1 valid=0",
                      in_ready[k], out_valid[k]);
    end
    total++;
    if (out_state[k] !== 128'h0) begin
      bad++; $display("FAIL midrst_clear got=%h exp=0", out_state[k]);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid[k] === 1'b1) late_out = 1'b1;
    end
    total++;
    if (late_out) begin
      bad++; $display("FAIL midrst_no_output got out_valid=1 exp=0");
    end
    run_one(k, 128'hffeeddccbbaa99887766554433221100,
            128'h1628c14beaaceec4f533fc1bc3938263, 1'b1);
  endtask

  task automatic test_random_one(input int k, input int n);
    int rd = 0;
    fork
      begin : producer
        int guard;
        int gap;
        for (int i = 0; i < n; i++) begin
          gap = ($urandom_range(3) == 0) ? int'($urandom_range(3)) : 0;
          repeat (gap) @(negedge clk);
          exp_mem[k][i] = {$urandom(), $urandom(), $urandom(), $urandom()};
          in_valid[k]   = 1'b1;
          in_state[k]   = exp_mem[k][i];
          guard = 0;
          while (in_ready[k] !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
          end
          if (guard >= 100) begin
            total++; bad++;
            $display("FAIL rnd_accept_timeout k=%0d item=%0d got=no accept exp=accept", k, i);
            break;
          end
          @(posedge clk);
          #1 in_valid[k] = 1'b0;
          @(negedge clk);
        end
        in_valid[k] = 1'b0;
      end
      begin : consumer
        int guard = 0;
        bit r;
        while (rd < n && guard < n * 40) begin
          @(negedge clk);
          guard++;
          r = ($urandom_range(3) != 0);
          out_ready[k] = r;
          if (out_valid[k] === 1'b1 && r) begin
            total++;
            if (out_state[k] !== ref_sub(exp_mem[k][rd])) begin
              bad++;
              $display("FAIL rnd_data k=%0d item=%0d got=%h exp=%h", k, rd, out_state[k],
                       ref_sub(exp_mem[k][rd]));
            end
            rd++;
          end
        end
        out_ready[k] = 1'b1;
      end
    join
    total++;
    if (rd != n) begin
      bad++; $display("FAIL rnd_count k=%0d got=%0d exp=%0d", k, rd, n);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    init_model();
    test_reset();
    test_zero();
    test_vector();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_busy();
    @(negedge clk);
    fork
      test_random_one(0, 2000);
      test_random_one(1, 2000);
      test_random_one(2, 2000);
      test_random_one(3, 2000);
      test_random_one(4, 2000);
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
